vend_dispense_ctrl: RTL and testbench
=====================================

# vend_dispense_ctrl

Downstream stage of the vending FSM. Consumes its per-cycle `out` (vend) and `change` (coins to return) codes, queues them in saturating pending counters, and drives the physical actuators: a timed product-motor pulse per vend and a timed ejector pulse per returned coin. Vends are serviced before change.

## Interface
Parameters:
- `MOTOR_CYCLES`, default 8: motor_en high time per vend, in cycles; must be ≥1.
- `EJECT_ON`, default 4: eject_en high time per coin; must be ≥1.
- `EJECT_GAP`, default 4: low time after each coin pulse; must be ≥1.
- `PEND_W`, default 3: width of each pending counter; saturates at 2^PEND_W−1.

Ports:
- `clk` in 1: clock, all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `vend_req` in 2: connects to the FSM `out`; any nonzero value is one vend request in that cycle.
- `change_req` in 2: connects to the FSM `change`; adds 0–3 coins in that cycle.
- `motor_en` out 1: product motor drive.
- `eject_en` out 1: coin ejector drive.
- `vend_done` out 1: one-cycle pulse on the last motor_en cycle.
- `coin_done` out 1: one-cycle pulse on the last eject_en cycle of each coin.
- `busy` out 1: state≠IDLE or either pending count ≠0.
- `overflow` out 1: sticky; set when either counter would exceed its max; cleared only by rst.
- `vend_pend` out PEND_W: pending vend count.
- `change_pend` out PEND_W: pending coin count.

## Operation
- All outputs are registered. Reset value of every output is 0, and the FSM is IDLE.
- Requests are sampled every cycle with no handshake. Each cycle is an independent event.
- Counter update each cycle: next = cnt + add − take, computed at PEND_W+2 bits.
  - If the result exceeds the max, clamp to the max and set overflow.
  - add and take in the same cycle are both honoured.
- FSM states: IDLE, MOTOR, EJECT_ON, EJECT_GAP.
  - IDLE, vend_pend≠0: take one vend, go to MOTOR, load the timer with MOTOR_CYCLES−1.
  - IDLE, vend_pend=0, change_pend≠0: take one coin, go to EJECT_ON, load the timer with EJECT_ON−1.
  - IDLE, both counts zero: remain IDLE.
  - MOTOR: motor_en=1. When the timer reaches 0, pulse vend_done and go to IDLE.
  - EJECT_ON: eject_en=1. When the timer reaches 0, pulse coin_done, load EJECT_GAP−1, and go to EJECT_GAP.
  - EJECT_GAP: both drives low. When the timer reaches 0, go to IDLE.
- Every operation passes through exactly one IDLE cycle before the next begins.
- Priority: vends always win in IDLE, so change can be deferred indefinitely by a continuous vend stream. This is accepted.
- Mutual exclusion: motor_en and eject_en are never high in the same cycle.
- Reset mid-operation: on the cycle after rst is sampled, both drives are low, counters are 0, overflow is 0, and no done pulse is emitted.

## Timing
- A request sampled at edge N makes the count visible from cycle N+1.
- IDLE takes the request at edge N+1. The drive goes high in cycle N+2.
- Latency from request to drive is 2 cycles.
- Per-vend occupancy: MOTOR_CYCLES + 1 cycles.
- Per-coin occupancy: EJECT_ON + EJECT_GAP + 1 cycles.
- Timer width: clog2 of the max of MOTOR_CYCLES, EJECT_ON and EJECT_GAP.

## Structure
- Shared package `vend_pkg` holds:
  - the state enum `disp_state_t`;
  - coin/change code constants (CHG_NONE=0, CHG_ONE=1, CHG_TWO=2);
  - default timing constants.
- Sub-module `vend_sat_counter`: a PEND_W up/down counter with add[1:0], take, and an overflow flag. It is instantiated twice, for vend and change.
- The FSM and the shared down-timer live in the top module.

## Test plan
Defaults are used unless stated.
1. Single vend: vend_req=1 in cycle 0.
   - motor_en high cycles 2–9.
   - vend_done pulses in cycle 9.
   - busy high cycles 1–9, low in cycle 10.
2. Change of two: change_req=2 in cycle 0.
   - eject_en high cycles 2–5 and 11–14.
   - coin_done pulses in cycles 5 and 14.
   - change_pend reads 2, then 1, then 0.
3. Simultaneous requests: vend_req=1 and change_req=1 in cycle 0.
   - motor_en high cycles 2–9.
   - eject_en high cycles 11–14.
   - The two drives never overlap.
4. Saturation (PEND_W=3): vend_req=1 in cycles 0–9.
   - overflow sets and stays high.
   - Exactly 8 motor pulses occur in total.
5. Reset mid-motor: vend_req=1 twice, then rst in cycle 5.
   - From cycle 6, motor_en=0, vend_pend=0, busy=0.
   - No vend_done is emitted.
6. Continuous vend stream with change pending:
   - No eject occurs until vend_pend reaches 0.
   - change_pend is preserved throughout.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending dispense stage.
// The FSM state enum, change codes and default actuator timings live here.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MOTOR,
    ST_EJECT_ON,
    ST_EJECT_GAP
  } disp_state_t;

  localparam logic [1:0] CHG_NONE = 2'd0;
  localparam logic [1:0] CHG_ONE  = 2'd1;
  localparam logic [1:0] CHG_TWO  = 2'd2;

  localparam int DEF_MOTOR_CYCLES = 8;
  localparam int DEF_EJECT_ON     = 4;
  localparam int DEF_EJECT_GAP    = 4;
  localparam int DEF_PEND_W       = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/vend_dispense_ctrl_if.sv
// Request/actuator bundle between the vending FSM and the dispense stage.
// The master side issues vend/change codes; the slave side drives the actuators.
interface vend_dispense_ctrl_if
  import vend_pkg::*;
#(
  parameter int PEND_W = DEF_PEND_W
);

  logic [1:0]        vend_req;
  logic [1:0]        change_req;
  logic              motor_en;
  logic              eject_en;
  logic              vend_done;
  logic              coin_done;
  logic              busy;
  logic              overflow;
  logic [PEND_W-1:0] vend_pend;
  logic [PEND_W-1:0] change_pend;

  modport master (
    output vend_req, change_req,
    input  motor_en, eject_en, vend_done, coin_done, busy, overflow,
           vend_pend, change_pend
  );

  modport slave (
    input  vend_req, change_req,
    output motor_en, eject_en, vend_done, coin_done, busy, overflow,
           vend_pend, change_pend
  );

endinterface

// File: rtl/vend_sat_counter.sv
// Saturating pending-work counter: adds 0-3 per cycle, removes one on take.
// `sat` flags a cycle whose result had to be clamped at the maximum.
module vend_sat_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   add,
  input  logic         take,
  output logic [W-1:0] cnt,
  output logic [W-1:0] cnt_next,
  output logic         sat
);

  localparam int MAX = (1 << W) - 1;

  logic [W-1:0] cnt_q, cnt_d;
  logic [W+1:0] sum;
  logic         take_ok;

  // Take is ignored on an empty counter so the wide sum can never wrap below zero.
  always_comb begin
    take_ok = take && (cnt_q != '0);
    sum     = {2'b00, cnt_q} + {{W{1'b0}}, add} - (W+2)'(take_ok);
    sat     = (sum > (W+2)'(MAX));
    cnt_d   = sat ? W'(MAX) : sum[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt      = cnt_q;
  assign cnt_next = cnt_d;

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Dispense stage: queues vend/change requests and drives timed motor and ejector
// pulses, vends first, with one IDLE cycle between consecutive operations.
module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int MOTOR_CYCLES = DEF_MOTOR_CYCLES,
  parameter int EJECT_ON     = DEF_EJECT_ON,
  parameter int EJECT_GAP    = DEF_EJECT_GAP,
  parameter int PEND_W       = DEF_PEND_W
) (
  input logic                 clk,
  input logic                 rst,
  vend_dispense_ctrl_if.slave bus
);

  localparam int TMAX = max3(MOTOR_CYCLES, EJECT_ON, EJECT_GAP);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  disp_state_t       state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              motor_en_q, motor_en_d;
  logic              eject_en_q, eject_en_d;
  logic              vend_done_q, vend_done_d;
  logic              coin_done_q, coin_done_d;
  logic              busy_q, busy_d;
  logic              overflow_q, overflow_d;
  logic              take_vend, take_coin;
  logic [PEND_W-1:0] vend_cnt, vend_next, chg_cnt, chg_next;
  logic              vend_sat, chg_sat;

  vend_sat_counter #(.W(PEND_W)) u_vend_cnt (
    .clk      (clk),
    .rst      (rst),
    .add      ({1'b0, |bus.vend_req}),
    .take     (take_vend),
    .cnt      (vend_cnt),
    .cnt_next (vend_next),
    .sat      (vend_sat)
  );

  vend_sat_counter #(.W(PEND_W)) u_chg_cnt (
    .clk      (clk),
    .rst      (rst),
    .add      (bus.change_req),
    .take     (take_coin),
    .cnt      (chg_cnt),
    .cnt_next (chg_next),
    .sat      (chg_sat)
  );

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    take_vend = 1'b0;
    take_coin = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (vend_cnt != '0) begin
          take_vend = 1'b1;
          state_d   = ST_MOTOR;
          timer_d   = TW'(MOTOR_CYCLES - 1);
        end else if (chg_cnt != '0) begin
          take_coin = 1'b1;
          state_d   = ST_EJECT_ON;
          timer_d   = TW'(EJECT_ON - 1);
        end
      end
      ST_MOTOR: begin
        if (timer_q == '0) state_d = ST_IDLE;
        else               timer_d = timer_q - TW'(1);
      end
      ST_EJECT_ON: begin
        if (timer_q == '0) begin
          state_d = ST_EJECT_GAP;
          timer_d = TW'(EJECT_GAP - 1);
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ST_EJECT_GAP: begin
        if (timer_q == '0) state_d = ST_IDLE;
        else               timer_d = timer_q - TW'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so the registered copies line up with it.
    motor_en_d  = (state_d == ST_MOTOR);
    eject_en_d  = (state_d == ST_EJECT_ON);
    vend_done_d = (state_d == ST_MOTOR) && (timer_d == '0);
    coin_done_d = (state_d == ST_EJECT_ON) && (timer_d == '0);
    busy_d      = (state_d != ST_IDLE) || (vend_next != '0) || (chg_next != '0);
    overflow_d  = overflow_q || vend_sat || chg_sat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      motor_en_q  <= 1'b0;
      eject_en_q  <= 1'b0;
      vend_done_q <= 1'b0;
      coin_done_q <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      motor_en_q  <= motor_en_d;
      eject_en_q  <= eject_en_d;
      vend_done_q <= vend_done_d;
      coin_done_q <= coin_done_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.motor_en    = motor_en_q;
  assign bus.eject_en    = eject_en_q;
  assign bus.vend_done   = vend_done_q;
  assign bus.coin_done   = coin_done_q;
  assign bus.busy        = busy_q;
  assign bus.overflow    = overflow_q;
  assign bus.vend_pend   = vend_cnt;
  assign bus.change_pend = chg_cnt;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Bench for vend_dispense_ctrl: an operation-scheduling model checked every cycle,
// plus directed scenarios with hand-computed cycle-exact expectations.
module tb_vend_dispense_ctrl;
  import vend_pkg::*;

  localparam int M    = 8;
  localparam int ON   = 4;
  localparam int GAP  = 4;
  localparam int MAXP = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] vend_req = 2'd0;
  logic [1:0] change_req = 2'd0;

  int tests = 0;
  int fails = 0;

  vend_dispense_ctrl_if bus ();
  assign bus.vend_req   = vend_req;
  assign bus.change_req = change_req;

  vend_dispense_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: tracks pending counts and the current operation window
  // (kind, start cycle, first free cycle) rather than any FSM encoding.
  int cyc = 0;
  bit m_valid = 0;
  int m_vp = 0, m_cp = 0, m_ovf = 0;
  int m_kind = 0, m_start = -100, m_free = 0;

  always @(posedge clk) begin
    int tv, tc, nv, nc;
    cyc++;
    if (rst) begin
      m_valid = 1;
      m_vp = 0; m_cp = 0; m_ovf = 0;
      m_kind = 0; m_start = -100; m_free = cyc;
    end else begin
      tv = 0; tc = 0;
      if (cyc - 1 >= m_free) begin
        if (m_vp > 0) begin
          tv = 1; m_kind = 1; m_start = cyc; m_free = cyc + M;
        end else if (m_cp > 0) begin
          tc = 1; m_kind = 2; m_start = cyc; m_free = cyc + ON + GAP;
        end
      end
      nv = m_vp + ((vend_req != 2'd0) ? 1 : 0) - tv;
      nc = m_cp + int'(change_req) - tc;
      if (nv > MAXP) begin nv = MAXP; m_ovf = 1; end
      if (nc > MAXP) begin nc = MAXP; m_ovf = 1; end
      m_vp = nv; m_cp = nc;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    int em, ee, evd, ecd, eb;
    if (m_valid && !rst) begin
      em  = (m_kind == 1 && cyc >= m_start && cyc < m_start + M) ? 1 : 0;
      evd = (m_kind == 1 && cyc == m_start + M - 1) ? 1 : 0;
      ee  = (m_kind == 2 && cyc >= m_start && cyc < m_start + ON) ? 1 : 0;
      ecd = (m_kind == 2 && cyc == m_start + ON - 1) ? 1 : 0;
      eb  = (cyc < m_free || m_vp != 0 || m_cp != 0) ? 1 : 0;
      checkOutput("motor_en", int'(bus.motor_en), em);
      checkOutput("eject_en", int'(bus.eject_en), ee);
      checkOutput("vend_done", int'(bus.vend_done), evd);
      checkOutput("coin_done", int'(bus.coin_done), ecd);
      checkOutput("busy", int'(bus.busy), eb);
      checkOutput("overflow", int'(bus.overflow), m_ovf);
      checkOutput("vend_pend", int'(bus.vend_pend), m_vp);
      checkOutput("change_pend", int'(bus.change_pend), m_cp);
      checkOutput("drive_mutex", int'(bus.motor_en & bus.eject_en), 0);
    end
  end

  // Pulse tallies sampled on the rising edge, i.e. from the previous cycle's outputs.
  int motor_pulses = 0, eject_pulses = 0, vend_dones = 0;
  logic prev_motor = 1'b0, prev_eject = 1'b0;
  always @(posedge clk) begin
    if (bus.motor_en === 1'b1 && prev_motor !== 1'b1) motor_pulses++;
    if (bus.eject_en === 1'b1 && prev_eject !== 1'b1) eject_pulses++;
    if (bus.vend_done === 1'b1) vend_dones++;
    prev_motor = bus.motor_en;
    prev_eject = bus.eject_en;
  end

  // One call is one cycle; returns at that cycle's falling edge.
  task automatic applyStimulus(input logic [1:0] v, input logic [1:0] c, input logic r);
    @(posedge clk);
    #1;
    vend_req   = v;
    change_req = c;
    rst        = r;
    @(negedge clk);
  endtask

  initial begin
    int base_m, base_e, base_d, bad_ej, bad_chg;

    applyStimulus(2'd0, CHG_NONE, 1'b1);
    applyStimulus(2'd0, CHG_NONE, 1'b1);
    applyStimulus(2'd0, CHG_NONE, 1'b0);
    checkOutput("reset_busy", int'(bus.busy), 0);
    checkOutput("reset_overflow", int'(bus.overflow), 0);
    checkOutput("reset_vend_pend", int'(bus.vend_pend), 0);

    $display("[TB] scenario 1: single vend");
    for (int r = 0; r < 14; r++) begin
      applyStimulus((r == 0) ? 2'd1 : 2'd0, CHG_NONE, 1'b0);
      if (r == 1) begin
        checkOutput("s1_pend_c1", int'(bus.vend_pend), 1);
        checkOutput("s1_busy_c1", int'(bus.busy), 1);
        checkOutput("s1_motor_c1", int'(bus.motor_en), 0);
      end
      if (r == 2) checkOutput("s1_motor_c2", int'(bus.motor_en), 1);
      if (r == 9) begin
        checkOutput("s1_motor_c9", int'(bus.motor_en), 1);
        checkOutput("s1_done_c9", int'(bus.vend_done), 1);
      end
      if (r == 10) begin
        checkOutput("s1_motor_c10", int'(bus.motor_en), 0);
        checkOutput("s1_busy_c10", int'(bus.busy), 0);
      end
    end

    $display("[TB] scenario 2: change of two");
    for (int r = 0; r < 22; r++) begin
      applyStimulus(2'd0, (r == 0) ? CHG_TWO : CHG_NONE, 1'b0);
      if (r == 1) checkOutput("s2_pend_c1", int'(bus.change_pend), 2);
      if (r == 2) begin
        checkOutput("s2_pend_c2", int'(bus.change_pend), 1);
        checkOutput("s2_eject_c2", int'(bus.eject_en), 1);
      end
      if (r == 5) checkOutput("s2_cdone_c5", int'(bus.coin_done), 1);
      if (r == 6) checkOutput("s2_eject_c6", int'(bus.eject_en), 0);
      if (r == 10) checkOutput("s2_eject_c10", int'(bus.eject_en), 0);
      if (r == 11) begin
        checkOutput("s2_eject_c11", int'(bus.eject_en), 1);
        checkOutput("s2_pend_c11", int'(bus.change_pend), 0);
      end
      if (r == 14) checkOutput("s2_cdone_c14", int'(bus.coin_done), 1);
      if (r == 19) checkOutput("s2_busy_c19", int'(bus.busy), 0);
    end

    $display("[TB] scenario 3: simultaneous vend and change");
    for (int r = 0; r < 22; r++) begin
      applyStimulus((r == 0) ? 2'd1 : 2'd0, (r == 0) ? CHG_ONE : CHG_NONE, 1'b0);
      if (r == 9) begin
        checkOutput("s3_motor_c9", int'(bus.motor_en), 1);
        checkOutput("s3_eject_c9", int'(bus.eject_en), 0);
      end
      if (r == 10) checkOutput("s3_eject_c10", int'(bus.eject_en), 0);
      if (r == 11) begin
        checkOutput("s3_eject_c11", int'(bus.eject_en), 1);
        checkOutput("s3_motor_c11", int'(bus.motor_en), 0);
      end
      if (r == 14) checkOutput("s3_cdone_c14", int'(bus.coin_done), 1);
    end

    $display("[TB] scenario 4: vend counter saturation");
    base_m = motor_pulses;
    for (int r = 0; r < 85; r++) begin
      applyStimulus((r < 10) ? 2'd1 : 2'd0, CHG_NONE, 1'b0);
      if (r == 8) begin
        checkOutput("s4_ovf_c8", int'(bus.overflow), 0);
        checkOutput("s4_pend_c8", int'(bus.vend_pend), 7);
      end
      if (r == 9) checkOutput("s4_ovf_c9", int'(bus.overflow), 1);
    end
    checkOutput("s4_ovf_sticky", int'(bus.overflow), 1);
    checkOutput("s4_motor_pulses", motor_pulses - base_m, 8);

    $display("[TB] scenario 5: reset during motor");
    base_d = vend_dones;
    for (int r = 0; r < 15; r++) begin
      applyStimulus((r < 2) ? 2'd1 : 2'd0, CHG_NONE, (r == 5) ? 1'b1 : 1'b0);
      if (r == 4) checkOutput("s5_motor_c4", int'(bus.motor_en), 1);
      if (r == 6) begin
        checkOutput("s5_motor_c6", int'(bus.motor_en), 0);
        checkOutput("s5_pend_c6", int'(bus.vend_pend), 0);
        checkOutput("s5_busy_c6", int'(bus.busy), 0);
        checkOutput("s5_ovf_c6", int'(bus.overflow), 0);
      end
    end
    checkOutput("s5_no_vend_done", vend_dones - base_d, 0);

    $display("[TB] scenario 6: vend stream defers change");
    base_e = eject_pulses;
    bad_ej = 0;
    bad_chg = 0;
    for (int r = 0; r < 130; r++) begin
      applyStimulus((r < 20) ? 2'd1 : 2'd0, (r == 0) ? CHG_ONE : CHG_NONE, 1'b0);
      if (bus.eject_en && bus.vend_pend != '0) bad_ej++;
      if (r >= 1 && bus.vend_pend != '0 && bus.change_pend != 3'd1) bad_chg++;
      if (r == 30) checkOutput("s6_chg_held_c30", int'(bus.change_pend), 1);
    end
    checkOutput("s6_eject_during_vends", bad_ej, 0);
    checkOutput("s6_change_preserved", bad_chg, 0);
    checkOutput("s6_one_coin", eject_pulses - base_e, 1);
    checkOutput("s6_chg_drained", int'(bus.change_pend), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
